// File: rtl/dda_state_streamer.sv
// ============================================================================
// dda_state_streamer : decimates Lorenz DDA state updates and streams each
//                      x/y/z snapshot as an 8-byte checksummed UART frame.
// Revision 1.0
// ============================================================================
`default_nettype none

module dda_state_streamer #(
  parameter int unsigned DECIM = 256,
  parameter logic [7:0]  SYNC  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        sample_valid,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_byte,
  output logic        frame_active,
  output logic        frame_done,
  output logic [7:0]  frames_dropped
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_ACK, ST_DRAIN} state_t;

  localparam logic [15:0] DCNT_LAST = 16'(DECIM - 1);

  state_t      state_q, state_d;
  logic [15:0] dcnt_q, dcnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] sx_q, sx_d, sy_q, sy_d, sz_q, sz_d;
  logic [7:0]  csum_q, csum_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        frame_active_q, frame_active_d;
  logic        frame_done_q, frame_done_d;
  logic [7:0]  dropped_q, dropped_d;
  logic        trigger;
  logic [7:0]  frame_byte;

  assign trigger = en && sample_valid && (dcnt_q == DCNT_LAST);

  always_comb begin
    frame_byte = SYNC;
    case (idx_q)
      3'd0: frame_byte = SYNC;
      3'd1: frame_byte = sx_q[15:8];
      3'd2: frame_byte = sx_q[7:0];
      3'd3: frame_byte = sy_q[15:8];
      3'd4: frame_byte = sy_q[7:0];
      3'd5: frame_byte = sz_q[15:8];
      3'd6: frame_byte = sz_q[7:0];
      3'd7: frame_byte = csum_q;
      default: frame_byte = SYNC;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    dcnt_d       = dcnt_q;
    idx_d        = idx_q;
    sx_d         = sx_q;
    sy_d         = sy_q;
    sz_d         = sz_q;
    csum_d       = csum_q;
    tx_start_d   = 1'b0;
    tx_byte_d    = tx_byte_q;
    frame_done_d = 1'b0;
    dropped_d    = dropped_q;

    if (!en) begin
      dcnt_d = 16'd0;
    end else if (sample_valid) begin
      dcnt_d = trigger ? 16'd0 : dcnt_q + 16'd1;
    end

    // Triggers landing while any frame is in flight (including its final
    // DRAIN edge) are dropped so the shadow snapshot stays coherent.
    if (trigger && state_q != ST_IDLE && dropped_q != 8'hFF) begin
      dropped_d = dropped_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          sx_d    = x;
          sy_d    = y;
          sz_d    = z;
          csum_d  = x[15:8] ^ x[7:0] ^ y[15:8] ^ y[7:0] ^ z[15:8] ^ z[7:0];
          idx_d   = 3'd0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_byte_d  = frame_byte;
          state_d    = ST_ACK;
        end
      end
      ST_ACK: begin
        if (tx_busy) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!tx_busy) begin
          if (idx_q == 3'd7) begin
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    frame_active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      dcnt_q         <= 16'd0;
      idx_q          <= 3'd0;
      sx_q           <= 16'd0;
      sy_q           <= 16'd0;
      sz_q           <= 16'd0;
      csum_q         <= 8'd0;
      tx_start_q     <= 1'b0;
      tx_byte_q      <= 8'h00;
      frame_active_q <= 1'b0;
      frame_done_q   <= 1'b0;
      dropped_q      <= 8'd0;
    end else begin
      state_q        <= state_d;
      dcnt_q         <= dcnt_d;
      idx_q          <= idx_d;
      sx_q           <= sx_d;
      sy_q           <= sy_d;
      sz_q           <= sz_d;
      csum_q         <= csum_d;
      tx_start_q     <= tx_start_d;
      tx_byte_q      <= tx_byte_d;
      frame_active_q <= frame_active_d;
      frame_done_q   <= frame_done_d;
      dropped_q      <= dropped_d;
    end
  end

  assign tx_start       = tx_start_q;
  assign tx_byte        = tx_byte_q;
  assign frame_active   = frame_active_q;
  assign frame_done     = frame_done_q;
  assign frames_dropped = dropped_q;

endmodule

`default_nettype wire

// File: tb/tb_dda_state_streamer.sv
// ============================================================================
// tb_dda_state_streamer : directed scoreboard bench for dda_state_streamer.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_dda_state_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] x = 16'h0, y = 16'h0, z = 16'h0;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        frame_active;
  logic        frame_done;
  logic [7:0]  frames_dropped;

  logic        force_busy = 1'b0;
  int          busy_cnt = 0;

  int          compared = 0;
  int          mismatched = 0;
  int          tx_total = 0;
  int          done_cnt = 0;
  logic [7:0]  sb[$];

  dda_state_streamer #(.DECIM(4), .SYNC(8'hA5)) dut (
    .clk(clk), .rst(rst), .en(en), .sample_valid(sample_valid),
    .x(x), .y(y), .z(z), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_byte(tx_byte), .frame_active(frame_active),
    .frame_done(frame_done), .frames_dropped(frames_dropped)
  );

  always #5 clk = ~clk;

  // UART model: busy rises on the edge after tx_start and holds 10 cycles.
  always @(posedge clk) begin
    if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    else if (tx_start === 1'b1) busy_cnt <= 10;
  end
  assign tx_busy = (busy_cnt != 0) || force_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [15:0] fx, input logic [15:0] fy, input logic [15:0] fz);
    sb.push_back(8'hA5);
    sb.push_back(fx[15:8]); sb.push_back(fx[7:0]);
    sb.push_back(fy[15:8]); sb.push_back(fy[7:0]);
    sb.push_back(fz[15:8]); sb.push_back(fz[7:0]);
    sb.push_back(fx[15:8] ^ fx[7:0] ^ fy[15:8] ^ fy[7:0] ^ fz[15:8] ^ fz[7:0]);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) sample_valid = 1'b1;
      @(negedge clk) sample_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_seen", 32'(done_cnt != d0), 32'd1);
  endtask

  task automatic wait_tx(input int target, input int budget);
    int n;
    n = 0;
    while (tx_total < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("tx_count_reached", 32'(tx_total >= target), 32'd1);
  endtask

  // Scoreboard monitor: every tx_start pops one expected byte.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (tx_start === 1'b1) begin
        tx_total++;
        compared++;
        assert (sb.size() != 0) else begin
          mismatched++;
          $error("FAIL unexpected_tx_start: observed byte %0h expected no start", tx_byte);
        end
        if (sb.size() != 0) chk("tx_byte", 32'(tx_byte), 32'(sb.pop_front()));
        chk("active_during_tx", 32'(frame_active), 32'd1);
      end
      if (frame_done === 1'b1) begin
        done_cnt++;
        chk("active_falls_with_done", 32'(frame_active), 32'd0);
        chk("frame_fully_sent", 32'(sb.size()), 32'd0);
      end
    end
  end

  initial begin
    int base;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte), 32'd0);
    chk("rst_frame_active", 32'(frame_active), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frames_dropped", 32'(frames_dropped), 32'd0);
    @(negedge clk) rst = 1'b0;
    en = 1'b1;

    // Basic frame, then snapshot isolation with one dropped trigger.
    x = 16'hC000; y = 16'h14CD; z = 16'h7240;
    push_frame(16'hC000, 16'h14CD, 16'h7240);
    base = tx_total;
    pulses(4);
    chk("basic_active", 32'(frame_active), 32'd1);
    @(negedge clk) x = 16'h0000;
    pulses(4);
    chk("drop_count_1", 32'(frames_dropped), 32'd1);
    wait_done(400);
    chk("basic_8_bytes", 32'(tx_total - base), 32'd8);
    repeat (40) @(negedge clk);
    chk("no_second_frame", 32'(tx_total - base), 32'd8);
    chk("idle_after_frame", 32'(frame_active), 32'd0);

    // Busy stall: first start exactly one edge after busy falls.
    x = 16'h1234; y = 16'hABCD; z = 16'h00FF;
    @(negedge clk) force_busy = 1'b1;
    push_frame(16'h1234, 16'hABCD, 16'h00FF);
    base = tx_total;
    pulses(4);
    repeat (20) @(negedge clk);
    chk("stall_no_start", 32'(tx_total - base), 32'd0);
    chk("stall_active", 32'(frame_active), 32'd1);
    force_busy = 1'b0;
    @(posedge clk);
    #1;
    chk("stall_release_start", 32'(tx_start), 32'd1);
    chk("stall_release_byte", 32'(tx_byte), 32'hA5);
    wait_done(400);

    // Enable gating.
    @(negedge clk) en = 1'b0;
    base = tx_total;
    pulses(10);
    @(negedge clk) en = 1'b1;
    pulses(3);
    repeat (30) @(negedge clk);
    chk("gated_no_frame", 32'(frame_active), 32'd0);
    chk("gated_no_start", 32'(tx_total - base), 32'd0);
    x = 16'h4000; y = 16'h8001; z = 16'h3C3C;
    push_frame(16'h4000, 16'h8001, 16'h3C3C);
    pulses(1);
    @(negedge clk);
    chk("gated_then_frame", 32'(frame_active), 32'd1);
    wait_done(400);

    // Reset during DRAIN of byte 3, then the next frame restarts at SYNC.
    x = 16'hDEAD; y = 16'hBEEF; z = 16'h0102;
    push_frame(16'hDEAD, 16'hBEEF, 16'h0102);
    base = tx_total;
    pulses(4);
    wait_tx(base + 4, 400);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_tx_start", 32'(tx_start), 32'd0);
    chk("midrst_tx_byte", 32'(tx_byte), 32'd0);
    chk("midrst_frame_active", 32'(frame_active), 32'd0);
    chk("midrst_frames_dropped", 32'(frames_dropped), 32'd0);
    sb.delete();
    @(negedge clk) rst = 1'b0;
    repeat (20) @(negedge clk);
    x = 16'h5555; y = 16'hAAAA; z = 16'h0F0F;
    push_frame(16'h5555, 16'hAAAA, 16'h0F0F);
    pulses(4);
    wait_done(400);

    // Saturation: stall a frame and pile triggers on top of it.
    @(negedge clk) force_busy = 1'b1;
    x = 16'h7777; y = 16'h8888; z = 16'h9999;
    push_frame(16'h7777, 16'h8888, 16'h9999);
    pulses(4);
    pulses(400);
    chk("drop_count_100", 32'(frames_dropped), 32'd100);
    pulses(800);
    chk("drop_saturated", 32'(frames_dropped), 32'd255);
    @(negedge clk) force_busy = 1'b0;
    wait_done(400);
    chk("sat_held", 32'(frames_dropped), 32'd255);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
